sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
- REQ-001: Parameter IN_W, default 5, width of the signed input sample (the upstream adder-bank result width).
- REQ-002: Parameter ACC_W, default 6, width of the signed accumulator and output sum.
- REQ-003: Parameter FRAME_LEN, default 4, number of samples per output frame; legal range 1 to 255.
- REQ-004: clk  in  1  single clock; all state SHALL update on its rising edge.
- REQ-005: rst_n  in  1  asynchronous, active-low reset.
- REQ-006: in_data  in  signed IN_W  input sample.
- REQ-007: in_valid  in  1  in_data is valid.
- REQ-008: in_ready  out  1  block can accept a sample.
- REQ-009: flush  in  1  close the current partial frame.
- REQ-010: clear  in  1  synchronous abort of the current frame.
- REQ-011: out_data  out  signed ACC_W  frame sum.
- REQ-012: out_count  out  CNT_W = $clog2(FRAME_LEN+1)  number of samples in the frame.
- REQ-013: out_valid  out  1  out_data, out_count and overflow are valid.
- REQ-014: out_ready  in  1  downstream accepts the frame.
- REQ-015: overflow  out  1  frame sum exceeded the ACC_W signed range.

Function
- REQ-016: The FSM SHALL have two states: ACCUM and HOLD.
- REQ-017: in_ready SHALL equal (state==ACCUM); a sample is accepted when in_valid and in_ready are both 1.
- REQ-018: Each accepted sample SHALL be sign-extended to ACC_W and added to the accumulator; the count SHALL increment by 1.
- REQ-019: On acceptance of the FRAME_LEN-th sample, the next state SHALL be HOLD, with out_valid=1 in the following cycle and out_data including that sample (latency 1).
- REQ-020: flush in ACCUM with count>0 SHALL enter HOLD; a sample accepted in the same cycle SHALL be included.
- REQ-021: flush with count==0 and no sample accepted SHALL be ignored.
- REQ-022: In HOLD, out_data, out_count and overflow SHALL be stable until out_valid and out_ready are both 1; flush SHALL be ignored in HOLD.
- REQ-023: The HOLD handshake SHALL return the FSM to ACCUM with accumulator, count and overflow zeroed; minimum period is FRAME_LEN+1 cycles per full frame.
- REQ-024: clear SHALL take priority over all other inputs: next state ACCUM, accumulator, count and overflow zeroed, out_valid=0; any sample presented in that cycle is dropped.
- REQ-025: overflow SHALL be sticky within a frame once any addition exceeds the signed ACC_W range.

Reset
- REQ-026: When rst_n=0: state=ACCUM, accumulator=0, count=0, out_valid=0, out_data=0, out_count=0, overflow=0, in_ready=1.
- REQ-027: Reset SHALL act immediately, even mid-frame or in HOLD; the pending frame is discarded.

Configuration
- REQ-028: With SUM_ACCUMULATOR_SAT_EN defined, each addition SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- REQ-029: Without SUM_ACCUMULATOR_SAT_EN, additions SHALL wrap in two's complement; overflow SHALL still be reported.

Structure
- REQ-030: Package sum_acc_pkg SHALL hold the state enum (ACCUM, HOLD) and the CNT_W width function.
- REQ-031: The saturating/wrapping adder with overflow detect SHALL be the sub-module sum_acc_add; the FSM and registers stay in sum_accumulator.

Verification (defaults IN_W=5, ACC_W=6, FRAME_LEN=4)
- REQ-032: Samples 3, -2, 7, 1 back-to-back -> one cycle after the last sample: out_valid=1, out_data=9, out_count=4, overflow=0, in_ready=0.
- REQ-033: Samples 15, 15, 15, 15 -> with SAT_EN: out_data=31, overflow=1; without SAT_EN: out_data=-4, overflow=1.
- REQ-034: Samples 5, 6, then flush together with sample 2 -> out_data=13, out_count=3.
- REQ-035: Full frame with out_ready held 0 for 5 cycles -> out_* stable and in_ready=0 throughout; handshake on cycle 6 -> next cycle in_ready=1, count=0.
- REQ-036: clear after 2 samples, then samples 1, 1, 1, 1 -> out_data=4, out_count=4.
- REQ-037: rst_n pulsed low in HOLD -> out_valid=0 and in_ready=1 immediately; the next frame sums from 0.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// Shared types and helpers for the sum_accumulator block.
// Holds the ACCUM/HOLD state encoding and the frame-count width function.
package sum_acc_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Enough bits to hold a count of 0..frame_len inclusive.
    function automatic int cnt_w(input int frame_len);
        return (frame_len < 1) ? 1 : $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/sum_acc_add.sv
// Signed accumulator adder with range-overflow detect.
// Clamps to the ACC_W range when SUM_ACCUMULATOR_SAT_EN is defined, otherwise wraps.
module sum_acc_add #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 6
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [IN_W-1:0]  sample,
    output logic signed [ACC_W-1:0] sum,
    output logic                    overflow
);

    // One guard bit above the wider operand keeps the true sum exact.
    localparam int EXT_W = ((ACC_W > IN_W) ? ACC_W : IN_W) + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_V = EXT_W'(-(2 ** (ACC_W - 1)));

    logic signed [EXT_W-1:0] wide;
    logic                    over_hi;
    logic                    over_lo;

    always_comb begin
        wide     = EXT_W'(acc) + EXT_W'(sample);
        over_hi  = (wide > MAX_V);
        over_lo  = (wide < MIN_V);
        overflow = over_hi || over_lo;
`ifdef SUM_ACCUMULATOR_SAT_EN
        if (over_hi) begin
            sum = MAX_V[ACC_W-1:0];
        end else if (over_lo) begin
            sum = MIN_V[ACC_W-1:0];
        end else begin
            sum = wide[ACC_W-1:0];
        end
`else
        sum = wide[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums FRAME_LEN signed samples (or a flushed partial frame)
// and holds the result until the downstream handshake. Option: SUM_ACCUMULATOR_SAT_EN.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int IN_W      = 5,
    parameter int ACC_W     = 6,
    parameter int FRAME_LEN = 4,
    localparam int CNT_W    = cnt_w(FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and held data stays put until transfer.

    state_e                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;
    logic                    valid_q;

    logic signed [ACC_W-1:0] add_sum;
    logic                    add_ovf;
    logic                    accept;
    logic                    last_sample;
    logic                    close_frame;

    sum_acc_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_add (
        .acc      (acc),
        .sample   (in_data),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    always_comb begin
        accept      = in_valid && (state == ACCUM);
        last_sample = accept && (cnt == CNT_W'(FRAME_LEN - 1));
        // A flush only closes a frame that will hold at least one sample.
        close_frame = last_sample || (flush && (state == ACCUM) && ((cnt != '0) || accept));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
        end else if (clear) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc <= add_sum;
                        cnt <= cnt + CNT_W'(1);
                        ovf <= ovf || add_ovf;
                    end
                    if (close_frame) begin
                        state   <= HOLD;
                        valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state   <= ACCUM;
                        acc     <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ACCUM;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = valid_q;
    assign out_data  = acc;
    assign out_count = cnt;
    assign overflow  = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed cases plus random traffic
// compared against a frame-level reference model (honours SUM_ACCUMULATOR_SAT_EN).
module tb_sum_accumulator;

    localparam int IN_W      = 5;
    localparam int ACC_W     = 6;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int EXP_W     = 1 + CNT_W + ACC_W;
    localparam int ACC_MAX   = (2 ** (ACC_W - 1)) - 1;
    localparam int ACC_MIN   = -(2 ** (ACC_W - 1));

    logic                    clk;
    logic                    rst_n;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic                    clear;
    logic signed [ACC_W-1:0] out_data;
    logic [CNT_W-1:0]        out_count;
    logic                    out_valid;
    logic                    out_ready;
    logic                    overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the samples of the open frame, and the expected held result.
    int              m_frame[$];
    bit              m_hold;
    logic [EXP_W-1:0] exp_q[$];

    sum_accumulator #(
        .IN_W      (IN_W),
        .ACC_W     (ACC_W),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .clear     (clear),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Sum the frame one addition at a time, wrapping or clamping each step.
    function automatic logic [EXP_W-1:0] frame_result();
        int s;
        bit o;
        s = 0;
        o = 1'b0;
        foreach (m_frame[i]) begin
            s = s + m_frame[i];
            if (s > ACC_MAX || s < ACC_MIN) o = 1'b1;
`ifdef SUM_ACCUMULATOR_SAT_EN
            if (s > ACC_MAX) s = ACC_MAX;
            if (s < ACC_MIN) s = ACC_MIN;
`else
            while (s > ACC_MAX) s = s - (2 ** ACC_W);
            while (s < ACC_MIN) s = s + (2 ** ACC_W);
`endif
        end
        return {o, CNT_W'(m_frame.size()), ACC_W'(s)};
    endfunction

    task automatic check_outputs(input string tag);
        logic [EXP_W-1:0]        e;
        logic signed [ACC_W-1:0] e_data;
        check({tag, "_out_valid"}, out_valid, m_hold);
        check({tag, "_in_ready"}, in_ready, !m_hold);
        if (m_hold && exp_q.size() > 0) begin
            e      = exp_q[0];
            e_data = e[ACC_W-1:0];
            check({tag, "_out_data"}, out_data, e_data);
            check({tag, "_out_count"}, out_count, e[ACC_W +: CNT_W]);
            check({tag, "_overflow"}, overflow, e[EXP_W-1]);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drive, let one rising edge pass, update model, check.
    task automatic cycle(input string tag, input logic v, input int d, input logic fl,
                         input logic cl, input logic ordy);
        in_valid  = v;
        in_data   = d[IN_W-1:0];
        flush     = fl;
        clear     = cl;
        out_ready = ordy;
        @(posedge clk);
        if (cl) begin
            m_hold = 1'b0;
            m_frame.delete();
            exp_q.delete();
        end else if (!m_hold) begin
            if (v) m_frame.push_back(d);
            if (m_frame.size() == FRAME_LEN || (fl && m_frame.size() > 0)) begin
                m_hold = 1'b1;
                exp_q.push_back(frame_result());
            end
        end else if (ordy) begin
            m_hold = 1'b0;
            m_frame.delete();
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic sample(input string tag, input int d);
        cycle(tag, 1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input logic ordy);
        cycle(tag, 1'b0, 0, 1'b0, 1'b0, ordy);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_count"}, out_count, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic v;
        logic fl;
        logic cl;
        logic ordy;
        int   d;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        m_hold    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, result one cycle after the last sample.
        sample("f1", 3);
        sample("f1", -2);
        sample("f1", 7);
        sample("f1", 1);
        check("f1_valid", out_valid, 1);
        check("f1_data", out_data, 9);
        check("f1_count", out_count, 4);
        check("f1_ovf", overflow, 0);
        check("f1_ready", in_ready, 0);
        idle("f1_hs", 1'b1);

        // Overflowing frame.
        for (int i = 0; i < 4; i++) sample("f2", 15);
`ifdef SUM_ACCUMULATOR_SAT_EN
        check("f2_data", out_data, 31);
`else
        check("f2_data", out_data, -4);
`endif
        check("f2_ovf", overflow, 1);
        idle("f2_hs", 1'b1);

        // Flush together with a sample closes a partial frame including it.
        sample("f3", 5);
        sample("f3", 6);
        cycle("f3_flush", 1'b1, 2, 1'b1, 1'b0, 1'b0);
        check("f3_data", out_data, 13);
        check("f3_count", out_count, 3);
        idle("f3_hs", 1'b1);

        // Backpressure: result held 5 cycles, flush ignored in HOLD.
        sample("f4", 1);
        sample("f4", 2);
        sample("f4", 3);
        sample("f4", 4);
        for (int i = 0; i < 5; i++) cycle("f4_hold", 1'b1, 9, 1'b1, 1'b0, 1'b0);
        check("f4_data", out_data, 10);
        idle("f4_hs", 1'b1);
        check("f4_after_ready", in_ready, 1);

        // Flush on an empty frame is ignored.
        cycle("f5_empty_flush", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("f5_valid", out_valid, 0);

        // Clear mid-frame drops the partial sum and the sample of that cycle.
        sample("f6", 7);
        sample("f6", 8);
        cycle("f6_clear", 1'b1, 7, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sample("f6", 1);
        check("f6_data", out_data, 4);
        check("f6_count", out_count, 4);

        // Clear beats the handshake while holding.
        cycle("f7_clear_hold", 1'b0, 0, 1'b0, 1'b1, 1'b1);
        check("f7_valid", out_valid, 0);

        // Asynchronous reset while holding.
        for (int i = 0; i < 4; i++) sample("f8", -3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("f8_rst");
        m_hold = 1'b0;
        m_frame.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        sample("f9", 2);
        sample("f9", 3);
        cycle("f9_flush", 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("f9_data", out_data, 5);
        idle("f9_hs", 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            d    = int'($urandom_range(0, (2 ** IN_W) - 1)) - (2 ** (IN_W - 1));
            fl   = ($urandom_range(0, 7) == 0);
            cl   = ($urandom_range(0, 31) == 0);
            ordy = ($urandom_range(0, 1) == 1);
            cycle("rand", v, d, fl, cl, ordy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
